// File: rtl/wb_write_arbiter_pkg.sv
// rtl/wb_write_arbiter_pkg.sv - shared widths and winner-source encoding for the writeback arbiter
package wb_write_arbiter_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_PIPE,
      SRC_FIFO,
      SRC_BYPASS
   } wb_src_e;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - writeback sources, scoreboard lookup and register-file write port bundle
interface wb_write_arbiter_if;
   import wb_write_arbiter_pkg::*;

   logic              pipe_valid;
   logic [REG_AW-1:0] pipe_rd;
   logic [XLEN-1:0]   pipe_data;
   logic              ml_valid;
   logic [REG_AW-1:0] ml_rd;
   logic [XLEN-1:0]   ml_data;
   logic              ml_ready;
   logic              iss_valid;
   logic [REG_AW-1:0] iss_rd;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic              busy1;
   logic              busy2;
   logic              WE3;
   logic [REG_AW-1:0] A3;
   logic [XLEN-1:0]   WD3;

   modport slave (
      input  pipe_valid, pipe_rd, pipe_data,
      input  ml_valid, ml_rd, ml_data,
      output ml_ready,
      input  iss_valid, iss_rd, rs1, rs2,
      output busy1, busy2,
      output WE3, A3, WD3
   );

   modport master (
      output pipe_valid, pipe_rd, pipe_data,
      output ml_valid, ml_rd, ml_data,
      input  ml_ready,
      output iss_valid, iss_rd, rs1, rs2,
      input  busy1, busy2,
      input  WE3, A3, WD3
   );

endinterface

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - small synchronous FIFO buffering long-latency results that lost arbitration
module wb_result_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CW-1:0]    count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Pointers wrap explicitly so non-power-of-two depths stay correct.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Next pointer and occupancy; simultaneous push and pop leaves count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push_i && reset_n) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges pipeline and long-latency results onto the single register-file write port
module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   wb_write_arbiter_if.slave bus
);
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int NREG = 1 << REG_AW;
   localparam int EW   = REG_AW + XLEN;

   logic [CW-1:0]     count;
   logic [EW-1:0]     head;
   logic              ml_ready;
   logic              ml_acc;
   logic              push;
   logic              pop;
   wb_src_e           src;
   logic [REG_AW-1:0] win_rd;
   logic [XLEN-1:0]   win_data;

   logic              we_q, we_d;
   logic [REG_AW-1:0] a3_q, a3_d;
   logic [XLEN-1:0]   wd3_q, wd3_d;
   logic [NREG-1:0]   pending_q, pending_d;

   // Ready depends only on registered occupancy, never on ml_valid.
   assign ml_ready = (count != CW'(DEPTH));
   assign ml_acc   = bus.ml_valid && ml_ready;

   // Strict-priority winner: pipeline, then buffered head, then bypass of a fresh result.
   always_comb begin
      src      = SRC_NONE;
      win_rd   = '0;
      win_data = '0;
      if (bus.pipe_valid) begin
         src      = SRC_PIPE;
         win_rd   = bus.pipe_rd;
         win_data = bus.pipe_data;
      end else if (count != '0) begin
         src      = SRC_FIFO;
         win_rd   = head[EW-1:XLEN];
         win_data = head[XLEN-1:0];
      end else if (ml_acc) begin
         src      = SRC_BYPASS;
         win_rd   = bus.ml_rd;
         win_data = bus.ml_data;
      end
   end

   // An accepted result that does not bypass joins the tail, keeping acceptance order.
   assign pop  = (src == SRC_FIFO);
   assign push = ml_acc && (src != SRC_BYPASS);

   wb_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (push),
      .push_data_i ({bus.ml_rd, bus.ml_data}),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count)
   );

   // Write-port next state and scoreboard update; an issue to the same rd outranks the clear.
   always_comb begin
      we_d      = 1'b0;
      a3_d      = a3_q;
      wd3_d     = wd3_q;
      pending_d = pending_q;
      if (src != SRC_NONE) begin
         we_d  = (win_rd != '0);
         a3_d  = win_rd;
         wd3_d = win_data;
      end
      if ((src == SRC_FIFO) || (src == SRC_BYPASS)) pending_d[win_rd] = 1'b0;
      if (bus.iss_valid && (bus.iss_rd != '0)) pending_d[bus.iss_rd] = 1'b1;
   end

   // Registered write port and pending bits with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         we_q      <= 1'b0;
         a3_q      <= '0;
         wd3_q     <= '0;
         pending_q <= '0;
      end else begin
         we_q      <= we_d;
         a3_q      <= a3_d;
         wd3_q     <= wd3_d;
         pending_q <= pending_d;
      end
   end

   assign bus.ml_ready = ml_ready;
   assign bus.busy1    = (bus.rs1 != '0) && pending_q[bus.rs1];
   assign bus.busy2    = (bus.rs2 != '0) && pending_q[bus.rs2];
   assign bus.WE3      = we_q;
   assign bus.A3       = a3_q;
   assign bus.WD3      = wd3_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - self-checking bench for wb_write_arbiter against a queue-based reference model
module tb_wb_write_arbiter;
   import wb_write_arbiter_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   wb_write_arbiter_if bus();

   wb_write_arbiter #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } ent_t;

   // Reference model: results waiting inside the arbiter, pending destinations, expected write port.
   ent_t mlq[$];
   ent_t mlsrc[$];
   bit   pend [32];
   logic              e_we  = 1'b0;
   logic [REG_AW-1:0] e_a3  = '0;
   logic [XLEN-1:0]   e_wd3 = '0;

   int n_checks = 0;
   int n_fail   = 0;
   bit known    = 1'b0;

   logic              s_rst   = 1'b0;
   logic              s_pv    = 1'b0;
   logic [REG_AW-1:0] s_prd   = '0;
   logic [XLEN-1:0]   s_pdata = '0;
   logic              s_iss   = 1'b0;
   logic [REG_AW-1:0] s_issrd = '0;
   logic [REG_AW-1:0] s_rs1   = '0;
   logic [REG_AW-1:0] s_rs2   = '0;

   logic [REG_AW-1:0] got[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive, check ready/busy mid-cycle, clock, advance model, check write port.
   task automatic step();
      bit   acc;
      bit   win;
      ent_t e;
      logic [REG_AW-1:0] wrd;
      logic [XLEN-1:0]   wdat;
      reset_n        = s_rst;
      bus.pipe_valid = s_pv;
      bus.pipe_rd    = s_prd;
      bus.pipe_data  = s_pdata;
      bus.iss_valid  = s_iss;
      bus.iss_rd     = s_issrd;
      bus.rs1        = s_rs1;
      bus.rs2        = s_rs2;
      bus.ml_valid   = (mlsrc.size() != 0);
      bus.ml_rd      = (mlsrc.size() != 0) ? mlsrc[0].rd : '0;
      bus.ml_data    = (mlsrc.size() != 0) ? mlsrc[0].data : '0;
      #1;
      if (known) begin
         chk("ml_ready", bus.ml_ready, mlq.size() < DEPTH);
         chk("busy1", bus.busy1, (s_rs1 != 0) && pend[s_rs1]);
         chk("busy2", bus.busy2, (s_rs2 != 0) && pend[s_rs2]);
      end
      @(posedge clk);
      #1;
      if (!s_rst) begin
         mlq.delete();
         foreach (pend[i]) pend[i] = 1'b0;
         e_we  = 1'b0;
         e_a3  = '0;
         e_wd3 = '0;
      end else begin
         acc  = (mlsrc.size() != 0) && (mlq.size() < DEPTH);
         win  = 1'b0;
         wrd  = '0;
         wdat = '0;
         if (acc) mlq.push_back(mlsrc.pop_front());
         if (s_pv) begin
            win  = 1'b1;
            wrd  = s_prd;
            wdat = s_pdata;
         end else if (mlq.size() != 0) begin
            e    = mlq.pop_front();
            win  = 1'b1;
            wrd  = e.rd;
            wdat = e.data;
            pend[wrd] = 1'b0;
         end
         if (win) begin
            e_we  = (wrd != 0);
            e_a3  = wrd;
            e_wd3 = wdat;
         end else begin
            e_we = 1'b0;
         end
         if (s_iss && s_issrd != 0) pend[s_issrd] = 1'b1;
      end
      known = 1'b1;
      chk("WE3", bus.WE3, e_we);
      chk("A3", bus.A3, e_a3);
      chk("WD3", bus.WD3, e_wd3);
   endtask

   task automatic idle();
      s_rst = 1'b1; s_pv = 1'b0; s_iss = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held two cycles with every input active.
      s_rst = 1'b0; s_pv = 1'b1; s_prd = 5'd6; s_pdata = 32'hAAAA5555;
      s_iss = 1'b1; s_issrd = 5'd3; s_rs1 = 5'd3; s_rs2 = 5'd6;
      mlsrc.push_back(ent_t'{rd: 5'd4, data: 32'h44});
      step();
      step();
      mlsrc.delete();
      chk("rst_WE3", bus.WE3, 1'b0);
      chk("rst_A3", bus.A3, 0);
      chk("rst_WD3", bus.WD3, 0);
      chk("rst_busy1", bus.busy1, 1'b0);
      chk("rst_ready", bus.ml_ready, 1'b1);

      // Pipeline write, one-cycle pulse.
      idle(); s_pv = 1'b1; s_prd = 5'd5; s_pdata = 32'hDEADBEEF;
      step();
      chk("pipe_WE3", bus.WE3, 1'b1);
      chk("pipe_A3", bus.A3, 5);
      chk("pipe_WD3", bus.WD3, 32'hDEADBEEF);
      idle();
      step();
      chk("pipe_pulse_end", bus.WE3, 1'b0);

      // Issue rd 7, then bypass its result.
      idle(); s_iss = 1'b1; s_issrd = 5'd7; s_rs1 = 5'd7;
      step();
      chk("iss_busy1", bus.busy1, 1'b1);
      idle();
      mlsrc.push_back(ent_t'{rd: 5'd7, data: 32'h12});
      step();
      chk("byp_WE3", bus.WE3, 1'b1);
      chk("byp_A3", bus.A3, 7);
      chk("byp_WD3", bus.WD3, 32'h12);
      chk("byp_busy1_clr", bus.busy1, 1'b0);

      // Pipeline held 4 cycles against three back-to-back long-latency results.
      idle(); s_pv = 1'b1; s_prd = 5'd20;
      mlsrc.push_back(ent_t'{rd: 5'd1, data: 32'h101});
      mlsrc.push_back(ent_t'{rd: 5'd2, data: 32'h202});
      mlsrc.push_back(ent_t'{rd: 5'd3, data: 32'h303});
      for (int i = 0; i < 4; i++) begin
         s_pdata = $urandom;
         step();
         if (i == 1) chk("full_ready_low", bus.ml_ready, 1'b0);
      end
      chk("rd3_held", mlsrc.size(), 1);
      idle();
      got.delete();
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.WE3) got.push_back(bus.A3);
      end
      chk("drain_count", got.size(), 3);
      if (got.size() == 3) begin
         chk("order0", got[0], 1);
         chk("order1", got[1], 2);
         chk("order2", got[2], 3);
      end

      // x0 result consumed without a write.
      idle();
      mlsrc.push_back(ent_t'{rd: 5'd0, data: 32'h55});
      step();
      chk("x0_WE3", bus.WE3, 1'b0);
      chk("x0_WD3", bus.WD3, 32'h55);
      chk("x0_consumed", mlsrc.size(), 0);

      // Issue of rd 9 in the same cycle its older result is written: set wins.
      idle(); s_iss = 1'b1; s_issrd = 5'd9; s_rs1 = 5'd9;
      step();
      mlsrc.push_back(ent_t'{rd: 5'd9, data: 32'h99});
      step();
      chk("race_WE3", bus.WE3, 1'b1);
      chk("race_busy1", bus.busy1, 1'b1);

      // Reset with two buffered results and three pending bits.
      idle(); s_iss = 1'b1; s_rs1 = 5'd10; s_rs2 = 5'd11;
      for (int r = 10; r < 13; r++) begin
         s_issrd = REG_AW'(r);
         step();
      end
      idle(); s_pv = 1'b1; s_prd = 5'd21;
      mlsrc.push_back(ent_t'{rd: 5'd10, data: 32'hA0});
      mlsrc.push_back(ent_t'{rd: 5'd11, data: 32'hB0});
      step();
      step();
      chk("mid_full", bus.ml_ready, 1'b0);
      chk("mid_busy2", bus.busy2, 1'b1);
      s_rst = 1'b0;
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_WE3", bus.WE3, 1'b0);
         chk("post_rst_busy1", bus.busy1, 1'b0);
         chk("post_rst_busy2", bus.busy2, 1'b0);
         chk("post_rst_ready", bus.ml_ready, 1'b1);
      end

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         s_rst   = ($urandom_range(99) != 0);
         s_pv    = ($urandom_range(2) != 0);
         s_prd   = REG_AW'($urandom_range(31));
         s_pdata = $urandom;
         s_iss   = $urandom_range(1);
         s_issrd = REG_AW'($urandom_range(15));
         s_rs1   = REG_AW'($urandom_range(15));
         s_rs2   = REG_AW'($urandom_range(15));
         if (mlsrc.size() == 0 && $urandom_range(1) == 0)
            mlsrc.push_back(ent_t'{rd: REG_AW'($urandom_range(15)), data: $urandom});
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-side front end of the register file: owns its single write port (WE3/A3/WD3) and merges two result sources into it.
- Source 1 is the in-order pipeline writeback (ALU/load), which can never stall. Source 2 is a long-latency unit (mul/div) with a valid/ready handshake.
- Holds a small FIFO for long-latency results that lose arbitration.
- Keeps a pending-write scoreboard that decode uses to detect RAW hazards on long-latency destinations.

Parameters:
- XLEN, 32, data width of register file words
- REG_AW, 5, register address width (32 registers)
- DEPTH, 2, long-latency result FIFO entries (>=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- pipe_valid  in  1  pipeline writeback valid this cycle
- pipe_rd  in  REG_AW  pipeline destination register
- pipe_data  in  XLEN  pipeline result
- ml_valid  in  1  long-latency result valid
- ml_rd  in  REG_AW  long-latency destination register
- ml_data  in  XLEN  long-latency result
- ml_ready  out  1  arbiter can accept a long-latency result
- iss_valid  in  1  long-latency op issued this cycle (marks rd pending)
- iss_rd  in  REG_AW  destination of issued long-latency op
- rs1  in  REG_AW  decode read address 1
- rs2  in  REG_AW  decode read address 2
- busy1  out  1  rs1 has a pending long-latency write
- busy2  out  1  rs2 has a pending long-latency write
- WE3  out  1  register file write enable (registered)
- A3  out  REG_AW  register file write address (registered)
- WD3  out  XLEN  register file write data (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low on reset_n, sampled on the rising edge.
- Reset values:
  - WE3=0, A3=0, WD3=0.
  - FIFO empty (count=0, read/write pointers=0).
  - Scoreboard all zeros.
  - ml_ready=1 in the cycle after reset.
- Reset mid-operation: buffered results and pending bits are discarded; no write is issued.
- ml handshake: a result is accepted when ml_valid && ml_ready. ml_ready = (count != DEPTH), from registered count only; no combinational path from ml_valid.
- Per-cycle winner selection, strict priority:
  1. pipe_valid: the pipeline result wins.
  2. FIFO non-empty: the FIFO head wins and is popped.
  3. FIFO empty and ml accepted this cycle: the ml result wins (bypass, no FIFO entry).
  4. Otherwise no write.
- An accepted ml result that does not win is pushed to the FIFO tail.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Ordering: long-latency results reach the register file in acceptance order, never reordered.
- Output latency: the winner is registered. WE3/A3/WD3 reflect it one cycle after selection, and WE3 is high for exactly that one cycle.
- x0 suppression: a winner with rd==0 is consumed (popped or accepted) but drives WE3=0. A3/WD3 still update to the winner.
- No winner: WE3=0; A3/WD3 hold their previous values.
- Scoreboard (pending[31:0]):
  - Set: iss_valid && iss_rd!=0 sets pending[iss_rd].
  - Clear: cleared on the edge where a long-latency-sourced winner with that rd is registered. Pipeline writes never clear pending bits.
  - Same-index set and clear in the same cycle: set wins.
  - busy1 = pending[rs1], busy2 = pending[rs2]; combinational from registered state. rs==0 always gives busy=0.
- Pipe starvation: sustained pipe_valid starves the FIFO. It fills, ml_ready drops, and the long-latency unit must hold its result (valid held, data stable) until ready.
- Overflow is impossible by construction. An ml_valid while ml_ready=0 is ignored.

Decomposition:
- Shared package holds XLEN, REG_AW, and a wb_src_e enum {SRC_NONE, SRC_PIPE, SRC_FIFO, SRC_BYPASS} used by the arbiter and its assertions.
- Natural sub-module: wb_result_fifo, a parameterised DEPTH x (REG_AW+XLEN) synchronous FIFO with push/pop/count and a synchronous active-low reset.
- Scoreboard and priority select stay in the top block.

Test Plan:
- Reset: hold reset_n=0 two cycles with all inputs active -> WE3=0, A3=0, WD3=0, busy1=busy2=0, ml_ready=1.
- Pipeline write: pipe_valid, rd=5, data=0xDEADBEEF -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; one cycle later WE3=0.
- Bypass plus scoreboard:
  - Issue rd=7 -> busy1=1 for rs1=7.
  - ml result rd=7, data=0x12 with FIFO empty and no pipe -> next cycle WE3=1, A3=7, WD3=0x12, and busy1=0 from that edge.
- Conflict and backpressure (DEPTH=2):
  - Stimulus: pipe_valid held 4 cycles; ml results rd=1, 2, 3 presented back-to-back.
  - rd=1 and rd=2 are buffered and ml_ready=0 after the second.
  - rd=3 is held until pipe_valid drops; writes then occur in the order 1, 2, 3.
- x0 and set/clear race:
  - ml result rd=0 -> consumed, WE3 stays 0.
  - iss_rd=9 issued in the same cycle that a pending rd=9 result is written -> busy stays 1.
- Reset mid-operation: FIFO holding 2 entries and 3 pending bits, then reset_n=0 for one edge -> count=0, pending=0, no further WE3 pulses.
